// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the delay-buffer read side (fifo_reader) and the
//   buffer-side write controller. Holds the drain FSM state encoding and a
//   small helper that classifies a state as busy.
//   No ports (package).
package fifo_pkg;

    typedef logic [1:0] fifo_state_t;

    // Drain FSM states, kept as plain constants so legacy code that compares
    // raw 2-bit state values keeps working.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    function automatic logic state_busy(input fifo_state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/fifo_reader.sv
// fifo_reader
//   Drains DEPTH entries, oldest first, from an upstream shift-style delay
//   buffer and hands them one at a time to a consumer over a valid/ready
//   handshake. A start pulse in IDLE begins a drain; abort cancels at once.
//
//   Ports
//     clk        sole clock, rising edge
//     rst_n      asynchronous active-low reset
//     start      single-cycle drain request, honoured only in IDLE
//     abort      synchronous cancel of the current drain
//     fifo_q     oldest entry presented by the buffer
//     fifo_en    shift strobe; the buffer advances one entry at this edge
//     fifo_d     fill word shifted into the buffer (always zero)
//     out_valid  out_data holds a valid word
//     out_ready  consumer accepts when out_valid && out_ready
//     out_data   registered word to the consumer
//     out_last   marks the DEPTH-th word
//     busy       high whenever the FSM is not IDLE
//     done       one-cycle pulse after the final handshake
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [BITS-1:0] fifo_q,
    output logic            fifo_en,
    output logic [BITS-1:0] fifo_d,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam int            CW   = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    fifo_state_t   state;
    fifo_state_t   state_nxt;
    logic [CW-1:0] count;
    logic          hs;

    // Next-state and shift strobe. The strobe doubles as the load enable for
    // out_data: every shift of the buffer captures the word being shifted out,
    // so the buffer and out_data can never drift apart. Abort overrides
    // everything, including a handshake in the same cycle, and suppresses the
    // strobe so the buffer is left untouched.
    always_comb begin
        state_nxt = state;
        fifo_en   = 1'b0;
        hs        = (state == ST_PRESENT) && out_ready;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                fifo_en   = 1'b1;
                state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (hs) begin
                    if (count == LAST) state_nxt = ST_DONE;
                    else               fifo_en   = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            fifo_en   = 1'b0;
        end
    end

    // State, word counter and output data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (fifo_en) out_data <= fifo_q;
            if (state == ST_FETCH) count <= '0;
            else if (fifo_en)      count <= count + 1'b1;
        end
    end

    // Outputs decoded from state so reset clears them without waiting for a
    // clock edge.
    assign out_valid = (state == ST_PRESENT);
    assign out_last  = out_valid && (count == LAST);
    assign busy      = state_busy(state);
    assign done      = (state == ST_DONE) && !abort;
    assign fifo_d    = '0;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, abort, ready;
    logic [63:0] fifo_q, fifo_d, out_data;
    logic        fifo_en, out_valid, out_last, busy, done;

    logic        start2, abort2, ready2;
    logic [15:0] fifo_q2, fifo_d2, out_data2;
    logic        fifo_en2, out_valid2, out_last2, busy2, done2;

    logic [63:0] buf8 [8];
    logic [15:0] buf2 [2];
    logic        load;
    logic [63:0] load_base;
    int          en_cnt, done_cnt, en_cnt2, done_cnt2;

    int tests = 0;
    int fails = 0;

    fifo_reader #(.DEPTH(8), .BITS(64)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .fifo_q(fifo_q), .fifo_en(fifo_en), .fifo_d(fifo_d),
        .out_valid(out_valid), .out_ready(ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    fifo_reader #(.DEPTH(2), .BITS(16)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .fifo_q(fifo_q2), .fifo_en(fifo_en2), .fifo_d(fifo_d2),
        .out_valid(out_valid2), .out_ready(ready2), .out_data(out_data2),
        .out_last(out_last2), .busy(busy2), .done(done2)
    );

    // Upstream delay-buffer models plus strobe/done counters.
    assign fifo_q  = buf8[0];
    assign fifo_q2 = buf2[0];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) buf8[i] <= load_base + 64'(i);
            for (int j = 0; j < 2; j++) buf2[j] <= load_base[15:0] + 16'(j);
            en_cnt    <= 0;
            done_cnt  <= 0;
            en_cnt2   <= 0;
            done_cnt2 <= 0;
        end else begin
            if (fifo_en) begin
                for (int i = 0; i < 7; i++) buf8[i] <= buf8[i+1];
                buf8[7] <= fifo_d;
            end
            if (fifo_en2) begin
                buf2[0] <= buf2[1];
                buf2[1] <= fifo_d2;
            end
            en_cnt    <= en_cnt    + int'(fifo_en);
            done_cnt  <= done_cnt  + int'(done);
            en_cnt2   <= en_cnt2   + int'(fifo_en2);
            done_cnt2 <= done_cnt2 + int'(done2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic load_cycle(input logic [63:0] base);
        load_base = base;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Full 8-word drain with ready held high; optional start pulse while
    // presenting word start_at (-1 for none).
    task automatic drain8(input logic [63:0] base, input int start_at);
        load_cycle(base);
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        chk("fetch_en", 64'(fifo_en), 64'd1);
        chk("fetch_busy", 64'(busy), 64'd1);
        chk("fetch_valid", 64'(out_valid), 64'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == start_at) start = 1'b1;
            settle();
            chk("word_data", out_data, base + 64'(k));
            chk("word_valid", 64'(out_valid), 64'd1);
            chk("word_last", 64'(out_last), 64'(k == 7));
            chk("word_en", 64'(fifo_en), 64'(k < 7));
            tick();
            start = 1'b0;
        end
        settle();
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_valid", 64'(out_valid), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        tick();
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("en_count", 64'(en_cnt), 64'd8);
        chk("done_count", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; ready = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b0;
        load = 1'b0; load_base = '0;

        // Reset state
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_en", 64'(fifo_en), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_fill", fifo_d, 64'd0);
        chk("rst_data2", 64'(out_data2), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic drain of 1..8
        drain8(64'd1, -1);

        // Stalled consumer: ready pattern 0,0,1 per word
        load_cycle(64'h10);
        start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        chk("stall_fetch_en", 64'(fifo_en), 64'd1);
        tick();
        for (int k = 0; k < 8; k++) begin
            ready = 1'b0;
            settle();
            for (int s = 0; s < 2; s++) begin
                chk("stall_hold", out_data, 64'h10 + 64'(k));
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_en", 64'(fifo_en), 64'd0);
                tick();
            end
            ready = 1'b1;
            settle();
            chk("stall_take", out_data, 64'h10 + 64'(k));
            chk("stall_take_en", 64'(fifo_en), 64'(k < 7));
            chk("stall_last", 64'(out_last), 64'(k == 7));
            tick();
        end
        ready = 1'b0;
        settle();
        chk("stall_done", 64'(done), 64'd1);
        tick();
        chk("stall_idle", 64'(busy), 64'd0);
        chk("stall_en_count", 64'(en_cnt), 64'd8);
        chk("stall_done_count", 64'(done_cnt), 64'd1);

        // Abort after the third handshake, together with a handshake
        load_cycle(64'h20);
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("abort_pre", out_data, 64'h20 + 64'(k));
            tick();
        end
        chk("abort_word3", out_data, 64'h23);
        abort = 1'b1;
        settle();
        chk("abort_en", 64'(fifo_en), 64'd0);
        chk("abort_nodone", 64'(done), 64'd0);
        tick();
        abort = 1'b0;
        settle();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_en_count", 64'(en_cnt), 64'd4);
        chk("abort_done_count", 64'(done_cnt), 64'd0);
        drain8(64'h30, -1);

        // Start while presenting is ignored
        drain8(64'h40, 3);
        tick();
        chk("no_restart", 64'(busy), 64'd0);

        // Start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        settle();
        chk("sa_en", 64'(fifo_en), 64'd0);
        tick();
        start = 1'b0;
        abort = 1'b0;
        settle();
        chk("sa_busy", 64'(busy), 64'd0);
        chk("sa_en2", 64'(fifo_en), 64'd0);

        // Reset during word 5
        load_cycle(64'h50);
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("mid_word5", out_data, 64'h54);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_en", 64'(fifo_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("post_rst_busy", 64'(busy), 64'd0);
        drain8(64'h60, -1);

        // DEPTH=2 instance: words A0, A1
        ready = 1'b0;
        load_cycle(64'hA0);
        ready2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        settle();
        chk("d2_fetch_en", 64'(fifo_en2), 64'd1);
        chk("d2_busy", 64'(busy2), 64'd1);
        tick();
        chk("d2_word_a", 64'(out_data2), 64'hA0);
        chk("d2_valid_a", 64'(out_valid2), 64'd1);
        chk("d2_last_a", 64'(out_last2), 64'd0);
        chk("d2_en_a", 64'(fifo_en2), 64'd1);
        tick();
        chk("d2_word_b", 64'(out_data2), 64'hA1);
        chk("d2_last_b", 64'(out_last2), 64'd1);
        chk("d2_en_b", 64'(fifo_en2), 64'd0);
        tick();
        chk("d2_done", 64'(done2), 64'd1);
        chk("d2_done_valid", 64'(out_valid2), 64'd0);
        tick();
        chk("d2_idle", 64'(busy2), 64'd0);
        chk("d2_en_count", 64'(en_cnt2), 64'd2);
        chk("d2_done_count", 64'(done_cnt2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
